seg_scan_disp: RTL and testbench

Parametrised multiplexed 7-segment display driver, the generalised successor to the fixed 6-digit scanner. Drives DIGITS common-select lines and one shared segment bus. Adds hex 0-F decode, per-digit decimal point and blanking, leading-zero suppression, and anti-ghost blanking. Display content is double-buffered and committed only at frame boundaries, so updates never tear. Sits between application logic (counters, clocks, status) and the board display pins.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_scan_disp_hex_dec.sv | 19 +
 rtl/seg_scan_disp.sv | 159 +++++++++++++++
 tb/tb_seg_scan_disp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the multiplexed 7-segment driver.
// Holds the active-low hex glyph table, the all-off pattern, the dp bit index
// and the polarity helper used for both the select lines and the segment bus.
package seg_pkg;

  // All segments (and dp) dark in active-low form.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit position of the decimal point on the segment bus.
  localparam int DP_BIT = 7;

  // Active-low glyphs for 0-F, bit7 = dp (kept dark here), bits6..0 = g..a.
  // Entry 0 sits in the lowest byte so HEX_LUT[v] returns the glyph for v.
  localparam logic [15:0][7:0] HEX_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Convert an active-low 8-bit pattern to the requested pin polarity.
  function automatic logic [7:0] to_pol(input logic [7:0] low_val,
                                        input logic      active_low);
    return active_low ? low_val : ~low_val;
  endfunction

endpackage

// File: rtl/seg_scan_disp_hex_dec.sv
// seg_hex_dec: combinational hex-to-segment decoder, active-low output.
// Ports: val (hex nibble), dp (1 = point lit), dark (1 = glyph segments off),
//        seg (bit7 = dp, bits6..0 = g..a, 0 = lit).
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  always_comb begin
    seg = dark ? SEG_OFF : HEX_LUT[val];
    // The point is honoured even on a dark digit.
    if (dp) seg[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg_scan_disp.sv
// seg_scan_disp: parametrised multiplexed 7-segment scanner with double-buffered
// content, hex decode, per-digit dp/blank, leading-zero suppression and anti-ghost
// blanking. Ports: clk, rst (async high), load/load_data/load_dp/load_blank/lz_en
// (shadow write), pending, frame_start, seg_sel (digit selects), seg_ment (segments).
module seg_scan_disp
  import seg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic                  lz_en,
  output logic                  pending,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_ment
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_DARK = to_pol(SEG_OFF, SEG_ACTIVE_LOW);

  // Scan position
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // Shadow (written by load) and active (displayed) buffers
  logic [DIGITS-1:0][3:0] sh_data,  act_data;
  logic [DIGITS-1:0]      sh_dp,    act_dp;
  logic [DIGITS-1:0]      sh_blank, act_blank;
  logic                   act_lz;

  logic slot_end;
  logic wrap;
  logic in_blank;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  // int cast keeps the compare signed so BLANK_CYC=0 simply never blanks.
  assign in_blank = (int'(cnt) < BLANK_CYC);

  // Leading-zero suppression: walk down from the top digit while every digit
  // seen so far is zero. Digit 0 is never part of the run.
  logic [DIGITS-1:0] supp;
  logic              zero_run;
  always_comb begin
    supp     = '0;
    zero_run = act_lz;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (act_data[i] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  // Current digit decode
  logic [3:0] cur_val;
  logic       cur_dp;
  logic       cur_dark;
  logic [7:0] dec_seg;

  assign cur_val  = act_data[idx];
  assign cur_dp   = act_dp[idx];
  assign cur_dark = act_blank[idx] | supp[idx];

  seg_hex_dec u_dec (
    .val  (cur_val),
    .dp   (cur_dp),
    .dark (cur_dark),
    .seg  (dec_seg)
  );

  // Select pattern for the current index, built active-low then polarised.
  logic [7:0]        sel_low8;
  logic [7:0]        sel_pol8;
  logic [DIGITS-1:0] sel_next;
  always_comb begin
    sel_low8 = ~(8'd1 << idx);
    sel_pol8 = to_pol(sel_low8, SEL_ACTIVE_LOW);
    sel_next = sel_pol8[DIGITS-1:0];
  end

  // Scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer. A load landing on the wrap cycle bypasses the shadow so it
  // is shown in the frame that starts right now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_lz      <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (load) begin
        sh_data  <= load_data;
        sh_dp    <= load_dp;
        sh_blank <= load_blank;
      end
      if (wrap && load) begin
        act_data  <= load_data;
        act_dp    <= load_dp;
        act_blank <= load_blank;
        act_lz    <= lz_en;
        pending   <= 1'b0;
      end else if (wrap && pending) begin
        act_data  <= sh_data;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        act_lz    <= lz_en;
        pending   <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
      end
    end
  end

  // Registered pin drive, one cycle behind (cnt, idx).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_sel  <= SEL_OFF;
      seg_ment <= SEG_DARK;
    end else if (in_blank) begin
      seg_sel  <= SEL_OFF;
      seg_ment <= SEG_DARK;
    end else begin
      seg_sel  <= sel_next;
      seg_ment <= to_pol(dec_seg, SEG_ACTIVE_LOW);
    end
  end

endmodule

// File: tb/tb_seg_scan_disp.sv
// tb_seg_scan_disp: directed, table-driven bench for seg_scan_disp with
// DIGITS=6, SCAN_DIV=8, BLANK_CYC=2 (48-cycle frames). Outputs are sampled
// on the falling clock edge.
module tb_seg_scan_disp;

  logic        clk;
  logic        rst;
  logic        load;
  logic [23:0] load_data;
  logic [5:0]  load_dp;
  logic [5:0]  load_blank;
  logic        lz_en;
  logic        pending;
  logic        frame_start;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_ment;

  int checks = 0;
  int errors = 0;

  seg_scan_disp #(
    .DIGITS(6), .SCAN_DIV(8), .BLANK_CYC(2),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .load_dp(load_dp), .load_blank(load_blank), .lz_en(lz_en),
    .pending(pending), .frame_start(frame_start),
    .seg_sel(seg_sel), .seg_ment(seg_ment)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  dp;
    logic [5:0]  blank;
    logic        lz;
    logic [47:0] exp;   // expected seg_ment per digit, digit d at [8d+7:8d]
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge where frame_start is high (state cnt=0, idx=0).
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_start expected pulse within 200 cycles");
    end
  endtask

  function automatic logic [5:0] sel_of(input int d);
    logic [5:0] one;
    one = 6'b000001 << d;
    return 6'h3F ^ one;
  endfunction

  vec_t vecs [6];
  logic [47:0] prev;
  int k;
  int gap;
  logic [7:0] want;

  initial begin
    rst = 1'b1; load = 1'b0; load_data = '0; load_dp = '0; load_blank = '0; lz_en = 1'b0;

    vecs[0] = '{24'h654321, 6'b000000, 6'b000000, 1'b0, 48'h82_92_99_B0_A4_F9};
    vecs[1] = '{24'h000120, 6'b000000, 6'b000000, 1'b1, 48'hFF_FF_FF_F9_A4_C0};
    vecs[2] = '{24'h000000, 6'b000000, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_FF_C0};
    vecs[3] = '{24'h654321, 6'b000100, 6'b000100, 1'b0, 48'h82_92_99_7F_A4_F9};
    vecs[4] = '{24'h0F0E09, 6'b100000, 6'b000000, 1'b1, 48'h7F_8E_C0_86_C0_90};
    vecs[5] = '{24'h000000, 6'b000000, 6'b000000, 1'b0, 48'hC0_C0_C0_C0_C0_C0};

    // ---- reset state and release timing ----
    #1;
    chk("rst_sel", 32'(seg_sel), 32'h3F);
    chk("rst_seg", 32'(seg_ment), 32'hFF);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    adv(2);
    rst = 1'b0;
    adv(1);
    chk("edge1_sel", 32'(seg_sel), 32'h3F);
    chk("edge1_seg", 32'(seg_ment), 32'hFF);
    adv(1);
    chk("edge2_sel", 32'(seg_sel), 32'h3F);
    chk("edge2_seg", 32'(seg_ment), 32'hFF);
    adv(1);
    chk("edge3_sel", 32'(seg_sel), 32'h3E);
    chk("edge3_seg", 32'(seg_ment), 32'hC0);
    adv(8);
    chk("edge11_sel", 32'(seg_sel), 32'h3D);
    chk("edge11_seg", 32'(seg_ment), 32'hC0);

    // ---- table-driven frames ----
    prev = 48'hC0_C0_C0_C0_C0_C0;
    for (int v = 0; v < 6; v++) begin
      wait_frame();
      load_data = vecs[v].data; load_dp = vecs[v].dp;
      load_blank = vecs[v].blank; lz_en = vecs[v].lz;
      load = 1'b1;
      adv(1);
      load = 1'b0;
      chk($sformatf("v%0d_pending", v), 32'(pending), 32'h1);
      adv(12);  // output now reflects idx=1, cnt=4 of the old frame
      chk($sformatf("v%0d_old_sel", v), 32'(seg_sel), 32'h3D);
      chk($sformatf("v%0d_old_seg", v), 32'(seg_ment), 32'(prev[15:8]));
      wait_frame();
      chk($sformatf("v%0d_committed", v), 32'(pending), 32'h0);
      k = 0;
      for (int d = 0; d < 6; d++) begin
        adv(8 * d + 5 - k);
        k = 8 * d + 5;
        want = vecs[v].exp[8*d +: 8];
        chk($sformatf("v%0d_d%0d_sel", v, d), 32'(seg_sel), 32'(sel_of(d)));
        chk($sformatf("v%0d_d%0d_seg", v, d), 32'(seg_ment), 32'(want));
      end
      prev = vecs[v].exp;
    end

    // ---- load coincident with the wrap cycle ----
    wait_frame();
    adv(47);
    load_data = 24'hFEDCBA; load_dp = 6'b000001; load_blank = '0; lz_en = 1'b0;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    chk("coin_fs", 32'(frame_start), 32'h1);
    chk("coin_pending", 32'(pending), 32'h0);
    adv(1);
    chk("coin_pending2", 32'(pending), 32'h0);
    chk("coin_fs_low", 32'(frame_start), 32'h0);
    k = 1;
    for (int d = 0; d < 6; d++) begin
      adv(8 * d + 5 - k);
      k = 8 * d + 5;
      case (d)
        0: want = 8'h08;
        1: want = 8'h83;
        2: want = 8'hC6;
        3: want = 8'hA1;
        4: want = 8'h86;
        default: want = 8'h8E;
      endcase
      chk($sformatf("coin_d%0d_seg", d), 32'(seg_ment), 32'(want));
    end
    // frame period: next pulse should come exactly 48 cycles after the last
    gap = k;
    for (int i = 0; i < 100 && !frame_start; i++) begin
      @(negedge clk);
      gap++;
    end
    chk("frame_period", 32'(gap), 32'd48);

    // ---- asynchronous reset mid-frame ----
    adv(1);   // k = 1 of this frame
    load_data = 24'h111111; load_dp = '0; load_blank = '0;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    chk("mid_pending", 32'(pending), 32'h1);
    adv(27);  // state idx=3, cnt=5
    chk("mid_sel_before", 32'(seg_sel), 32'h37);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sel", 32'(seg_sel), 32'h3F);
    chk("async_seg", 32'(seg_ment), 32'hFF);
    chk("async_pending", 32'(pending), 32'h0);
    adv(3);
    rst = 1'b0;
    adv(3);
    chk("restart_sel", 32'(seg_sel), 32'h3E);
    chk("restart_seg", 32'(seg_ment), 32'hC0);
    wait_frame();
    adv(5);
    chk("restart_frame_sel", 32'(seg_sel), 32'h3E);
    chk("restart_frame_seg", 32'(seg_ment), 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
